// File: rtl/fast_square_bb_quant_pkg.sv
// Shared constants and helpers for the fast-square baseband slicer/packer.
package fast_square_bb_quant_pkg;

    localparam int DEF_IN_WIDTH      = 16;
    localparam int DEF_OUT_WIDTH     = 16;
    localparam int DEF_DC_SHIFT      = 16;
    localparam int DEF_HYST          = 0;
    localparam int DEF_HOLDOFF_WORDS = 201;

    function automatic int acc_width(input int in_width, input int dc_shift);
        return in_width + dc_shift;
    endfunction

    // Marker word: only the MSB of the output word set.
    function automatic logic [31:0] marker_word(input int out_width);
        return 32'd1 << (out_width - 1);
    endfunction

endpackage

// File: rtl/fast_square_bb_quant_chan.sv
// One channel: DC-tracking integrator, hysteresis slicer and bit shift register.
module fast_square_bb_quant_chan
    import fast_square_bb_quant_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int DC_SHIFT  = DEF_DC_SHIFT,
    parameter int HYST      = DEF_HYST
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_strobe,
    input  logic                 dc_freeze,
    input  logic                 restart,
    input  logic [IN_WIDTH-1:0]  sample,
    output logic [OUT_WIDTH-1:0] sr_next
);

    localparam int AW = acc_width(IN_WIDTH, DC_SHIFT);
    localparam logic signed [IN_WIDTH+1:0] HYST_POS = (IN_WIDTH+2)'(HYST);
    localparam logic signed [IN_WIDTH+1:0] HYST_NEG = -HYST_POS;

    logic signed [AW-1:0]       acc_r;
    logic                       last_bit_r;
    logic [OUT_WIDTH-1:0]       sr_r;
    logic signed [IN_WIDTH-1:0] est_s;
    logic signed [IN_WIDTH:0]   incr_s;
    logic signed [IN_WIDTH+1:0] diff_s;
    logic                       slice_bit_s;

    assign est_s   = $signed(acc_r[AW-1 -: IN_WIDTH]);
    assign incr_s  = (IN_WIDTH+1)'($signed(sample)) - (IN_WIDTH+1)'(est_s);
    assign diff_s  = (IN_WIDTH+2)'($signed(sample)) - (IN_WIDTH+2)'(est_s);
    assign sr_next = {sr_r[OUT_WIDTH-2:0], slice_bit_s};

    // Slicer: inside the hysteresis band the previous decision is repeated.
    always_comb begin
        slice_bit_s = last_bit_r;
        if (diff_s > HYST_POS) begin
            slice_bit_s = 1'b1;
        end else if (diff_s <= HYST_NEG) begin
            slice_bit_s = 1'b0;
        end else begin
            slice_bit_s = last_bit_r;
        end
    end

    // Integrator, slicer memory and shift register; restart spares the DC estimate.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_r      <= '0;
            last_bit_r <= 1'b0;
            sr_r       <= '0;
        end else begin
            if (in_strobe && !dc_freeze) begin
                acc_r <= acc_r + AW'(incr_s);
            end
            if (in_strobe) begin
                last_bit_r <= slice_bit_s;
            end
            if (restart) begin
                sr_r <= '0;
            end else if (in_strobe) begin
                sr_r <= sr_next;
            end
        end
    end

endmodule

// File: rtl/fast_square_bb_quant.sv
// Dual-channel 1-bit baseband quantiser with word packing and post-restart marker holdoff.
module fast_square_bb_quant
    import fast_square_bb_quant_pkg::*;
#(
    parameter int IN_WIDTH      = DEF_IN_WIDTH,
    parameter int OUT_WIDTH     = DEF_OUT_WIDTH,
    parameter int DC_SHIFT      = DEF_DC_SHIFT,
    parameter int HYST          = DEF_HYST,
    parameter int HOLDOFF_WORDS = DEF_HOLDOFF_WORDS
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_strobe,
    input  logic [IN_WIDTH-1:0]  i_in,
    input  logic [IN_WIDTH-1:0]  q_in,
    input  logic                 dc_freeze,
    input  logic                 restart,
    output logic                 out_strobe,
    output logic [OUT_WIDTH-1:0] i_out,
    output logic [OUT_WIDTH-1:0] q_out,
    output logic                 holdoff_active
);

    localparam int CW = $clog2(OUT_WIDTH);
    localparam int WW = (HOLDOFF_WORDS > 0) ? $clog2(HOLDOFF_WORDS + 1) : 1;
    localparam logic [CW-1:0] LAST_BIT  = CW'(OUT_WIDTH - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(HOLDOFF_WORDS - 1);
    localparam logic          HOLD_INIT = (HOLDOFF_WORDS > 0) ? 1'b1 : 1'b0;
    localparam logic [31:0]   MARKER_FULL = marker_word(OUT_WIDTH);
    localparam logic [OUT_WIDTH-1:0] MARKER    = MARKER_FULL[OUT_WIDTH-1:0];
    localparam logic [OUT_WIDTH-1:0] RESET_OUT = HOLD_INIT ? MARKER : '0;

    logic [CW-1:0]        bit_cnt_r;
    logic [WW-1:0]        word_cnt_r;
    logic [OUT_WIDTH-1:0] i_word_s;
    logic [OUT_WIDTH-1:0] q_word_s;
    logic                 word_done_s;

    fast_square_bb_quant_chan #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .DC_SHIFT(DC_SHIFT), .HYST(HYST)
    ) u_chan_i (
        .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe), .dc_freeze(dc_freeze),
        .restart(restart), .sample(i_in), .sr_next(i_word_s)
    );

    fast_square_bb_quant_chan #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .DC_SHIFT(DC_SHIFT), .HYST(HYST)
    ) u_chan_q (
        .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe), .dc_freeze(dc_freeze),
        .restart(restart), .sample(q_in), .sr_next(q_word_s)
    );

    // A restart in the completing cycle discards that word.
    assign word_done_s = in_strobe && !restart && (bit_cnt_r == LAST_BIT);

    // Bit/word counters, holdoff tracking and the registered output words.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bit_cnt_r      <= '0;
            word_cnt_r     <= '0;
            holdoff_active <= HOLD_INIT;
            out_strobe     <= 1'b0;
            i_out          <= RESET_OUT;
            q_out          <= RESET_OUT;
        end else begin
            out_strobe <= word_done_s;
            if (restart) begin
                bit_cnt_r      <= '0;
                word_cnt_r     <= '0;
                holdoff_active <= HOLD_INIT;
            end else if (in_strobe) begin
                if (bit_cnt_r == LAST_BIT) begin
                    bit_cnt_r <= '0;
                end else begin
                    bit_cnt_r <= bit_cnt_r + CW'(1);
                end
                if (word_done_s) begin
                    i_out <= holdoff_active ? MARKER : i_word_s;
                    q_out <= holdoff_active ? MARKER : q_word_s;
                    if (holdoff_active) begin
                        word_cnt_r <= word_cnt_r + WW'(1);
                        if (word_cnt_r == LAST_WORD) begin
                            holdoff_active <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fast_square_bb_quant.sv
// Drives a default-parameter and a small-parameter instance with shared stimulus against a behavioural model.
module tb_fast_square_bb_quant;

    logic        clock = 1'b0;
    logic        reset_n, in_strobe, dc_freeze, restart;
    logic [15:0] i_in, q_in;
    logic        out_strobe_a, holdoff_a, out_strobe_b, holdoff_b;
    logic [15:0] i_out_a, q_out_a;
    logic [7:0]  i_out_b, q_out_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clock = ~clock;

    fast_square_bb_quant u_dut_a (
        .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe), .i_in(i_in), .q_in(q_in),
        .dc_freeze(dc_freeze), .restart(restart), .out_strobe(out_strobe_a),
        .i_out(i_out_a), .q_out(q_out_a), .holdoff_active(holdoff_a)
    );

    fast_square_bb_quant #(
        .IN_WIDTH(16), .OUT_WIDTH(8), .DC_SHIFT(4), .HYST(8), .HOLDOFF_WORDS(3)
    ) u_dut_b (
        .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe), .i_in(i_in), .q_in(q_in),
        .dc_freeze(dc_freeze), .restart(restart), .out_strobe(out_strobe_b),
        .i_out(i_out_b), .q_out(q_out_b), .holdoff_active(holdoff_b)
    );

    // Reference state, index [instance][channel]
    longint m_acc[2][2];
    int     m_prev[2][2];
    longint m_word[2][2];
    longint m_out[2][2];
    int     m_nbits[2];
    int     m_wcnt[2];
    int     m_hold[2];
    int     m_stb[2];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic longint wrap(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    task automatic model_step(input int k);
        int     ow, s, h, hw, b;
        longint est, d, marker;
        longint smp[2];
        ow = (k == 0) ? 16 : 8;
        s  = (k == 0) ? 16 : 4;
        h  = (k == 0) ? 0 : 8;
        hw = (k == 0) ? 201 : 3;
        marker = longint'(1) << (ow - 1);
        if (!reset_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_acc[k][ch]  = 0;
                m_prev[k][ch] = 0;
                m_word[k][ch] = 0;
                m_out[k][ch]  = (hw > 0) ? marker : 0;
            end
            m_nbits[k] = 0;
            m_wcnt[k]  = 0;
            m_hold[k]  = (hw > 0) ? 1 : 0;
            m_stb[k]   = 0;
            return;
        end
        smp[0] = longint'($signed(i_in));
        smp[1] = longint'($signed(q_in));
        m_stb[k] = 0;
        if (in_strobe) begin
            for (int ch = 0; ch < 2; ch++) begin
                est = m_acc[k][ch] >>> s;
                d   = smp[ch] - est;
                if (d > h) b = 1;
                else if (d <= -h) b = 0;
                else b = m_prev[k][ch];
                m_prev[k][ch] = b;
                m_word[k][ch] = ((m_word[k][ch] << 1) | b) & ((longint'(1) << ow) - 1);
                if (!dc_freeze) m_acc[k][ch] = wrap(m_acc[k][ch] + d, 16 + s);
            end
        end
        if (restart) begin
            m_word[k][0] = 0;
            m_word[k][1] = 0;
            m_nbits[k]   = 0;
            m_wcnt[k]    = 0;
            m_hold[k]    = (hw > 0) ? 1 : 0;
        end else if (in_strobe) begin
            m_nbits[k]++;
            if (m_nbits[k] == ow) begin
                m_nbits[k] = 0;
                m_stb[k]   = 1;
                for (int ch = 0; ch < 2; ch++)
                    m_out[k][ch] = (m_hold[k] != 0) ? marker : m_word[k][ch];
                if (m_hold[k] != 0) begin
                    m_wcnt[k]++;
                    if (m_wcnt[k] == hw) m_hold[k] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step(0);
        model_step(1);
        @(negedge clock);
        cyc++;
        check("a_stb",  out_strobe_a, m_stb[0]);
        check("a_i",    i_out_a,      m_out[0][0]);
        check("a_q",    q_out_a,      m_out[0][1]);
        check("a_hold", holdoff_a,    m_hold[0]);
        check("b_stb",  out_strobe_b, m_stb[1]);
        check("b_i",    i_out_b,      m_out[1][0]);
        check("b_q",    q_out_b,      m_out[1][1]);
        check("b_hold", holdoff_b,    m_hold[1]);
    endtask

    task automatic align_b(input string tag);
        int found;
        found = 0;
        for (int t = 0; t < 20 && found == 0; t++) begin
            tick();
            if (out_strobe_b) found = 1;
        end
        check(tag, found, 1);
    endtask

    initial begin
        int nstb, last, gap, seen;
        int hseq[8];
        logic [7:0] prev_b;
        hseq = '{20, 5, -5, -20, -5, 0, 0, 0};

        reset_n = 1'b0; in_strobe = 1'b0; dc_freeze = 1'b0; restart = 1'b0;
        i_in = 16'd0; q_in = 16'd0;
        repeat (3) tick();
        check("rst_a_i", i_out_a, 16'h8000);
        check("rst_a_hold", holdoff_a, 1);
        check("rst_a_stb", out_strobe_a, 0);
        check("rst_b_i", i_out_b, 8'h80);

        // Holdoff at defaults with constant input 100
        reset_n = 1'b1; in_strobe = 1'b1; i_in = 16'd100; q_in = 16'd100;
        nstb = 0; last = -1;
        repeat (201 * 16 + 40) begin
            tick();
            if (out_strobe_a) begin
                nstb++;
                if (last >= 0) check("a_period", cyc - last, 16);
                last = cyc;
                if (nstb == 200) check("a_hold200", holdoff_a, 1);
                if (nstb == 201) begin
                    check("a_hold201", holdoff_a, 0);
                    check("a_mark201", i_out_a, 16'h8000);
                end
                if (nstb == 202) check("a_data202", i_out_a, 16'hFFFF);
            end
        end
        check("a_nstb", nstb, 203);

        // DC convergence then alternating input on the small instance
        i_in = 16'd1000; q_in = 16'($signed(-500));
        repeat (600) tick();
        seen = 0;
        for (int t = 0; t < 64; t++) begin
            i_in = (t % 2 == 0) ? 16'd1010 : 16'd990;
            tick();
            if (out_strobe_b) begin
                seen++;
                if (seen == 2 || seen == 3)
                    check("b_alt", (i_out_b == 8'hAA || i_out_b == 8'h55) ? 1 : 0, 1);
            end
        end

        // Hysteresis: settle est at 0, freeze it, then a word-aligned sequence
        i_in = 16'd0; q_in = 16'd0;
        repeat (300) tick();
        align_b("b_align_h");
        dc_freeze = 1'b1;
        for (int t = 0; t < 8; t++) begin
            i_in = 16'(hseq[t]);
            tick();
        end
        check("b_hyst_stb", out_strobe_b, 1);
        check("b_hyst_word", i_out_b, 8'hE0);
        dc_freeze = 1'b0;

        // Sparse strobes every third clock
        nstb = 0; last = -1; prev_b = i_out_b;
        for (int t = 0; t < 8 * 3 * 6; t++) begin
            in_strobe = (t % 3 == 0);
            i_in = 16'($urandom); q_in = 16'($urandom);
            tick();
            if (out_strobe_b) begin
                if (last >= 0) check("b_sparse_period", cyc - last, 24);
                last = cyc;
                nstb++;
            end else begin
                check("b_sparse_hold", i_out_b, prev_b);
            end
            prev_b = i_out_b;
        end
        check("b_sparse_n", nstb, 6);

        // Restart at bit 5 of a word
        in_strobe = 1'b1;
        align_b("b_align_r");
        repeat (5) begin
            i_in = 16'($urandom);
            tick();
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        last = cyc; gap = -1;
        for (int t = 0; t < 40; t++) begin
            i_in = 16'($urandom);
            tick();
            if (out_strobe_b && gap < 0) begin
                gap = cyc - last;
                check("b_rst_mark", i_out_b, 8'h80);
            end
        end
        check("b_rst_lat", gap, 8);

        // Random traffic with freezes, restarts and resets
        repeat (4000) begin
            in_strobe = ($urandom_range(0, 3) != 0);
            i_in      = 16'($urandom);
            q_in      = 16'($urandom);
            dc_freeze = ($urandom_range(0, 15) == 0);
            restart   = ($urandom_range(0, 499) == 0);
            reset_n   = ($urandom_range(0, 999) != 0);
            tick();
        end

        // Reset mid-word
        restart = 1'b0; dc_freeze = 1'b0; reset_n = 1'b1; in_strobe = 1'b1;
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        check("rst2_a_i", i_out_a, 16'h8000);
        check("rst2_a_hold", holdoff_a, 1);
        check("rst2_b_stb", out_strobe_b, 0);
        check("rst2_b_q", q_out_b, 8'h80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fast_square_bb_quant.md
Name: fast_square_bb_quant

Overview:
- Parametrised successor to the fixed 16-bit fast-square baseband slicer.
- Per I/Q channel: tracks the DC level with a programmable-time-constant integrator, slices each valid sample to 1 bit (optional hysteresis), and packs OUT_WIDTH bits per output word.
- Emits a marker word for a programmable holdoff after reset or restart.
- Sits between the RX decimation chain and the RX FIFO packer; consumes sample strobes instead of free-running every clock.

Parameters:
- IN_WIDTH, 16, signed input sample width.
- OUT_WIDTH, 16, bits per packed output word (range 2..32).
- DC_SHIFT, 16, integrator fraction bits; DC time constant is 2^DC_SHIFT valid samples.
- HYST, 0, slicer hysteresis in input LSBs (0 = plain comparator).
- HOLDOFF_WORDS, 201, number of marker words emitted after reset/restart (0 = none).

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- in_strobe  in  1  i_in/q_in valid this cycle.
- i_in  in  IN_WIDTH  signed I sample.
- q_in  in  IN_WIDTH  signed Q sample.
- dc_freeze  in  1  hold both DC integrators.
- restart  in  1  single-cycle pulse; re-enters holdoff (e.g. on freq_step).
- out_strobe  out  1  one-cycle pulse, new word on i_out/q_out.
- i_out  out  OUT_WIDTH  packed I bits or marker.
- q_out  out  OUT_WIDTH  packed Q bits or marker.
- holdoff_active  out  1  high while marker words are being emitted.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low on reset_n, sampled at the clock edge.
- Reset state:
  - Integrators, shift registers, bit counter and word counter are 0.
  - out_strobe = 0; holdoff_active = 1 (0 if HOLDOFF_WORDS = 0).
  - i_out/q_out = MARKER = 1 << (OUT_WIDTH-1), i.e. 0x8000 at defaults (0 if HOLDOFF_WORDS = 0).
- DC integrator (per channel):
  - Accumulator acc is signed, IN_WIDTH+DC_SHIFT bits; est = acc[top IN_WIDTH bits].
  - incr = in - est, computed at IN_WIDTH+1 bits with no wrap, then sign-extended.
  - On in_strobe && !dc_freeze: acc <= acc + incr. Otherwise acc holds.
- Slicer (per channel, on in_strobe):
  - d = in - est, computed at IN_WIDTH+2 bits.
  - bit = 1 if d > HYST.
  - bit = 0 if d <= -HYST.
  - Otherwise bit repeats the previous bit (reset value 0).
  - With HYST = 0 this reduces exactly to in > est.
- Packing:
  - On in_strobe: sr <= {sr[OUT_WIDTH-2:0], bit}, so the newest bit is the LSB and the oldest is the MSB.
  - bit_cnt counts 0..OUT_WIDTH-1 and wraps.
  - When in_strobe arrives with bit_cnt == OUT_WIDTH-1, then on the next cycle:
    - out_strobe = 1 for one cycle;
    - i_out/q_out load the completed words (MARKER instead while holdoff_active).
  - Latency: 1 clock from the in_strobe of the final bit.
  - Outputs hold their value between strobes.
- Holdoff:
  - word_cnt increments on each out_strobe while holdoff_active.
  - holdoff_active falls in the same cycle as the HOLDOFF_WORDS-th marker strobe. The next word is real data.
- Restart:
  - Clears sr, bit_cnt and word_cnt, and sets holdoff_active.
  - Does not touch acc, so the DC estimate persists.
  - i_out/q_out hold their last value until the next strobe.
- Simultaneous events:
  - restart with in_strobe: restart wins; the sample is not packed, but acc still updates.
  - restart in the cycle a word completes: out_strobe for that word is suppressed.
  - reset_n low overrides everything.
- dc_freeze does not affect slicing or packing.
- in_strobe may be high every clock (full rate) or sparse; no backpressure.

Decomposition:
- Shared include/package fast_square_defs:
  - MARKER function of OUT_WIDTH;
  - default parameter constants;
  - accumulator width expression IN_WIDTH+DC_SHIFT.
- Sub-module fast_square_chan, instantiated twice (I, Q). It contains the integrator, slicer with hysteresis memory, and shift register; it outputs the current sr.
- Top level owns bit_cnt, word_cnt, holdoff, restart handling and the output registers.

Test Plan:
- Holdoff at defaults: reset, then in_strobe every clock with constant i_in = q_in = 100 -> out_strobe every 16 clocks; the first 201 words are 0x8000 with holdoff_active high; holdoff_active falls with the 201st strobe.
- DC convergence, slicing and packing: DC_SHIFT = 4, constant input 1000 until est = 1000, then i_in alternating 1010/990 -> i_out = 0xAAAA or 0x5555 depending on phase; q_in = -500 constant -> q_out = 0x0000 once settled.
- Hysteresis: HYST = 8, est settled at 0, sequence +20, +5, -5, -20, -5 -> bits 1, 1, 1, 0, 0.
- Sparse strobe with OUT_WIDTH = 8: in_strobe every 3rd clock -> out_strobe exactly 1 clock after the 8th strobe, i.e. every 24 clocks; outputs stable in between.
- Restart mid-word: after holdoff, pulse restart with in_strobe at bit 5 -> no strobe for the partial word; the next HOLDOFF_WORDS words are MARKER; est is unchanged across restart.
- Reset and freeze: pull reset_n low mid-word -> the next cycle shows the reset state. dc_freeze high during an input step of +300 -> est is constant and slicing continues against the old est.
